eth_rx_switch_scheduler: RTL

Generates the 3-bit channel selects for a bank of 4-way RX switches. Those switches share four RX FIFO channels and feed separate NoC streams. The block tracks complete packets waiting in each RX FIFO and offers each switch a ready, unclaimed channel by round robin. It never offers one channel to two switches at once. It sits between the RX FIFOs and the switches and drives the switches' select and shared active-channel inputs.

---
 rtl/eth_rx_sched_pkg.sv | 38 +++
 rtl/eth_rx_pkt_counter.sv | 52 +++++
 rtl/eth_rx_switch_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/eth_rx_sched_pkg.sv
// Shared types and helpers for the RX switch channel scheduler.
//   NUM_CH / SEL_W : channel count and switch select width (fixed by the
//                    4-way switch select encoding).
//   SEL_NONE       : select code meaning "no channel offered".
//   offer_state_e  : per-switch offer state.
//   first_eligible : round-robin pick of the first set bit after 'start'.
package eth_rx_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] SEL_NONE = 3'b100;

  typedef enum logic {
    OFF_NONE  = 1'b0,
    OFF_VALID = 1'b1
  } offer_state_e;

  // Scans start+1, start+2, ... wrapping, and finishes on start itself.
  // Callers only use the result when mask is non-zero.
  function automatic logic [1:0] first_eligible(input logic [NUM_CH-1:0] mask,
                                                input logic [1:0]        start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = start + 2'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/eth_rx_pkt_counter.sv
// Pending-packet counter for one RX FIFO channel.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_wr           : a complete packet was written into the FIFO
//   i_rd           : a packet's eop left the FIFO through a switch
//   o_cnt          : packets currently waiting
//   o_ovf, o_udf   : sticky overflow / underflow flags, cleared by reset
module eth_rx_pkt_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_wr,
  input  logic         i_rd,
  output logic [W-1:0] o_cnt,
  output logic         o_ovf,
  output logic         o_udf
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (i_wr && !i_rd) begin
      if (&cnt_q) ovf_d = 1'b1;
      else        cnt_d = cnt_q + W'(1);
    end else if (i_rd && !i_wr) begin
      if (cnt_q == '0) udf_d = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign o_cnt = cnt_q;
  assign o_ovf = ovf_q;
  assign o_udf = udf_q;

endmodule

// File: rtl/eth_rx_switch_scheduler.sv
// Offers ready, unclaimed RX FIFO channels to a bank of 4-way RX switches.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_pkt_wr/rd     : per-channel packet written / eop transferred pulses
//   i_sw_active     : per-switch active-channel vectors (slice s = switch s)
//   i_frame_start   : per-switch pulse, the switch consumed its select
//   i_sw_enable     : per-switch permission to receive offers
//   o_sel           : per-switch registered select, 3'b1xx = none
//   o_active_ch     : OR of all active-channel slices
//   o_pkt_cnt       : pending packets per channel
//   o_cnt_err       : sticky [c] overflow, [NUM_CH+c] underflow
//
// state     | meaning
// OFF_NONE  | no channel offered, o_sel = 3'b100
// OFF_VALID | channel ch_q offered, o_sel = {0, ch_q}
module eth_rx_switch_scheduler
  import eth_rx_sched_pkg::*;
#(
  parameter int NUM_SW    = 4,
  parameter int PKT_CNT_W = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_CH-1:0]           i_pkt_wr,
  input  logic [NUM_CH-1:0]           i_pkt_rd,
  input  logic [NUM_SW*NUM_CH-1:0]    i_sw_active,
  input  logic [NUM_SW-1:0]           i_frame_start,
  input  logic [NUM_SW-1:0]           i_sw_enable,
  output logic [NUM_SW*SEL_W-1:0]     o_sel,
  output logic [NUM_CH-1:0]           o_active_ch,
  output logic [NUM_CH*PKT_CNT_W-1:0] o_pkt_cnt,
  output logic [2*NUM_CH-1:0]         o_cnt_err
);

  localparam int TURN_W = (NUM_SW > 1) ? $clog2(NUM_SW) : 1;

  logic [TURN_W-1:0] turn_q, turn_d;
  offer_state_e      state_q [NUM_SW];
  offer_state_e      state_d [NUM_SW];
  logic [1:0]        ch_q    [NUM_SW];
  logic [1:0]        ch_d    [NUM_SW];
  logic [1:0]        rr_q    [NUM_SW];
  logic [1:0]        rr_d    [NUM_SW];

  logic [NUM_CH-1:0] cnt_nz;
  logic [NUM_CH-1:0] offered;
  logic [NUM_CH-1:0] eligible;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt
    eth_rx_pkt_counter #(.W(PKT_CNT_W)) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_wr    (i_pkt_wr[c]),
      .i_rd    (i_pkt_rd[c]),
      .o_cnt   (o_pkt_cnt[c*PKT_CNT_W +: PKT_CNT_W]),
      .o_ovf   (o_cnt_err[c]),
      .o_udf   (o_cnt_err[NUM_CH+c])
    );
    assign cnt_nz[c] = |o_pkt_cnt[c*PKT_CNT_W +: PKT_CNT_W];
  end

  always_comb begin
    o_active_ch = '0;
    for (int s = 0; s < NUM_SW; s++) o_active_ch |= i_sw_active[s*NUM_CH +: NUM_CH];
  end

  // Only the turn holder can allocate, and it is in OFF_NONE when it does,
  // so masking every live offer is the same as masking "other" switches.
  always_comb begin
    offered = '0;
    for (int s = 0; s < NUM_SW; s++)
      if (state_q[s] == OFF_VALID) offered[ch_q[s]] = 1'b1;
  end

  assign eligible = cnt_nz & ~o_active_ch & ~offered;

  assign turn_d = (turn_q == TURN_W'(NUM_SW-1)) ? '0 : turn_q + TURN_W'(1);

  always_comb begin
    for (int s = 0; s < NUM_SW; s++) begin
      state_d[s] = state_q[s];
      ch_d[s]    = ch_q[s];
      rr_d[s]    = rr_q[s];
      case (state_q[s])
        OFF_NONE: begin
          if (turn_q == TURN_W'(s) && i_sw_enable[s] && (|eligible)) begin
            state_d[s] = OFF_VALID;
            ch_d[s]    = first_eligible(eligible, rr_q[s]);
            rr_d[s]    = first_eligible(eligible, rr_q[s]);
          end
        end
        OFF_VALID: begin
          if (i_frame_start[s] || !i_sw_enable[s]) state_d[s] = OFF_NONE;
        end
        default: state_d[s] = OFF_NONE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      turn_q <= '0;
      for (int s = 0; s < NUM_SW; s++) begin
        state_q[s] <= OFF_NONE;
        ch_q[s]    <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      turn_q <= turn_d;
      for (int s = 0; s < NUM_SW; s++) begin
        state_q[s] <= state_d[s];
        ch_q[s]    <= ch_d[s];
        rr_q[s]    <= rr_d[s];
      end
    end
  end

  always_comb begin
    o_sel = '0;
    for (int s = 0; s < NUM_SW; s++)
      o_sel[s*SEL_W +: SEL_W] = (state_q[s] == OFF_VALID) ? {1'b0, ch_q[s]} : SEL_NONE;
  end

endmodule
